// File: rtl/wb_cmd_pkg.sv
// Shared constants for the Wishbone command master: response status codes,
// FSM state encoding and the width helper for the timeout counter.
package wb_cmd_pkg;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Never returns zero so a one-cycle timeout still gets a 1-bit counter.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating wait-state counter: cleared to zero, counts up while enabled,
// and flags the cycle on which it sits at its terminal value LIMIT-1.
module wb_timeout_cnt #(
    parameter int LIMIT = 255,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: one host command in, one bus cycle out, one
// response back, with a bounded timeout for addresses nobody acknowledges.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_data_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_data_o,
    output logic [1:0]              rsp_status_o,
    output logic                    busy_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] state;
    logic       timed_out;

    // Counter is held clear in IDLE so every bus cycle starts from zero.
    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (CW)
    ) u_timeout (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (state == S_IDLE),
        .enable   (state == S_BUS),
        .terminal (timed_out)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_status_o <= ST_OK;
            busy_o       <= 1'b0;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        wb_we_o     <= cmd_we_i;
                        wb_adr_o    <= cmd_addr_i;
                        wb_dat_o    <= cmd_data_i;
                        wb_sel_o    <= cmd_sel_i;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= S_BUS;
                    end
                end

                // Priority: err beats ack, and ack beats the timeout limit.
                S_BUS: begin
                    if (wb_err_i || wb_ack_i || timed_out) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                        if (wb_err_i) begin
                            rsp_status_o <= ST_ERR;
                            rsp_data_o   <= '0;
                        end else if (wb_ack_i) begin
                            rsp_status_o <= ST_OK;
                            rsp_data_o   <= wb_we_o ? '0 : wb_dat_i;
                        end else begin
                            rsp_status_o <= ST_TIMEOUT;
                            rsp_data_o   <= '0;
                        end
                    end
                end

                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    cmd_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    wb_cyc_o    <= 1'b0;
                    wb_stb_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed cases then random transactions
// compared against a transaction-level model of the expected bus/response outcome.
module tb_wb_cmd_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_addr_i;
    logic [DW-1:0] cmd_data_i;
    logic [SW-1:0] cmd_sel_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_data_o;
    logic [1:0]    rsp_status_o;
    logic          busy_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [SW-1:0] wb_sel_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    int errors = 0;
    int checks = 0;

    wb_cmd_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_addr_i   (cmd_addr_i),
        .cmd_data_i   (cmd_data_i),
        .cmd_sel_i    (cmd_sel_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .rsp_status_o (rsp_status_o),
        .busy_o       (busy_o),
        .wb_cyc_o     (wb_cyc_o),
        .wb_stb_o     (wb_stb_o),
        .wb_we_o      (wb_we_o),
        .wb_adr_o     (wb_adr_o),
        .wb_dat_o     (wb_dat_o),
        .wb_sel_o     (wb_sel_o),
        .wb_dat_i     (wb_dat_i),
        .wb_ack_i     (wb_ack_i),
        .wb_err_i     (wb_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, cmd_ready_o, 1);
        checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
        checkOutput({tag, "_busy"}, busy_o, 0);
        checkOutput({tag, "_cyc"}, wb_cyc_o, 0);
        checkOutput({tag, "_stb"}, wb_stb_o, 0);
        checkOutput({tag, "_we"}, wb_we_o, 0);
        checkOutput({tag, "_adr"}, wb_adr_o, 0);
        checkOutput({tag, "_dat"}, wb_dat_o, 0);
        checkOutput({tag, "_sel"}, wb_sel_o, 0);
        checkOutput({tag, "_rsp_data"}, rsp_data_o, 0);
        checkOutput({tag, "_rsp_status"}, rsp_status_o, 0);
    endtask

    // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = slave never answers.
    // The slave answers on bus cycle waitStates+1 unless the timeout fires first.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input logic [SW-1:0] sel,
                                 input int waitStates, input int kind,
                                 input logic [DW-1:0] rdata, input int rspDelay,
                                 input bit holdValid);
        bit            answers;
        int            expLen;
        logic [1:0]    expStatus;
        logic [DW-1:0] expData;
        int            len;
        bit            busBad;
        bit            rspBad;
        answers   = (kind != 3) && (waitStates + 1 <= TO);
        expLen    = answers ? waitStates + 1 : TO;
        expStatus = !answers ? 2'b10 : ((kind == 0) ? 2'b00 : 2'b01);
        expData   = (answers && kind == 0 && !we) ? rdata : '0;

        @(negedge clk_i);
        checkOutput("idle_ready", cmd_ready_o, 1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_data_i  = data;
        cmd_sel_i   = sel;
        @(negedge clk_i);
        cmd_valid_i = holdValid;
        checkOutput("busy_after_accept", busy_o, 1);
        checkOutput("ready_in_bus", cmd_ready_o, 0);
        checkOutput("wb_adr", wb_adr_o, addr);
        checkOutput("wb_we", wb_we_o, we);
        checkOutput("wb_dat_o", wb_dat_o, data);
        checkOutput("wb_sel", wb_sel_o, sel);

        len    = 0;
        busBad = 1'b0;
        while (wb_cyc_o && len < 40) begin
            len++;
            if (wb_stb_o !== 1'b1 || wb_adr_o !== addr || wb_dat_o !== data ||
                wb_we_o !== we || wb_sel_o !== sel || cmd_ready_o !== 1'b0)
                busBad = 1'b1;
            if (kind != 3 && len == waitStates + 1) begin
                wb_ack_i = (kind != 1);
                wb_err_i = (kind != 0);
                wb_dat_i = rdata;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
            @(negedge clk_i);
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        checkOutput("cyc_len", len, expLen);
        checkOutput("bus_stable", busBad, 0);
        checkOutput("stb_drop", wb_stb_o, 0);
        checkOutput("rsp_valid", rsp_valid_o, 1);
        checkOutput("rsp_data", rsp_data_o, expData);
        checkOutput("rsp_status", rsp_status_o, expStatus);

        // Stray acks/errs while waiting must not disturb the held response.
        rspBad = 1'b0;
        for (int i = 0; i < rspDelay; i++) begin
            wb_ack_i = 1'($urandom_range(0, 1));
            wb_err_i = 1'($urandom_range(0, 1));
            wb_dat_i = $urandom;
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b1 || rsp_data_o !== expData ||
                rsp_status_o !== expStatus || cmd_ready_o !== 1'b0 || wb_cyc_o !== 1'b0)
                rspBad = 1'b1;
        end
        checkOutput("rsp_hold", rspBad, 0);
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        checkOutput("rsp_valid_clear", rsp_valid_o, 0);
        checkOutput("ready_after_rsp", cmd_ready_o, 1);
        checkOutput("busy_after_rsp", busy_o, 0);
    endtask

    task automatic resetMidBus();
        bit stray;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = 16'h0077;
        cmd_data_i  = 32'hA5A5_5A5A;
        cmd_sel_i   = 4'h3;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        checkOutput("midrst_cyc_up", wb_cyc_o, 1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkResetValues("midrst");
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o !== 1'b0 || wb_cyc_o !== 1'b0) stray = 1'b1;
        end
        checkOutput("midrst_no_rsp", stray, 0);
    endtask

    initial begin
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        cmd_sel_i   = '0;
        rsp_ready_i = 1'b0;
        wb_dat_i    = '0;
        wb_ack_i    = 1'b0;
        wb_err_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        checkResetValues("reset");

        $display("[TB] read with two wait states");
        applyStimulus(1'b0, 16'h0003, 32'h0, 4'hF, 2, 0, 32'hDEAD_BEEF, 0, 1'b0);
        $display("[TB] write acked in first cycle");
        applyStimulus(1'b1, 16'h0010, 32'h1234_5678, 4'hF, 0, 0, 32'hCAFE_F00D, 0, 1'b0);
        $display("[TB] timeout then normal command");
        applyStimulus(1'b0, 16'h0042, 32'h0, 4'hF, 0, 3, 32'h1111_2222, 1, 1'b0);
        applyStimulus(1'b1, 16'h0044, 32'h0BAD_CAFE, 4'h5, 1, 0, 32'h3333_4444, 0, 1'b0);
        $display("[TB] error and tie-break cases");
        applyStimulus(1'b0, 16'h0050, 32'h0, 4'hF, 1, 2, 32'h5555_6666, 0, 1'b0);
        applyStimulus(1'b0, 16'h0051, 32'h0, 4'hF, TO - 1, 0, 32'h7777_8888, 0, 1'b0);
        applyStimulus(1'b1, 16'h0052, 32'hFFFF_0000, 4'h8, 3, 1, 32'h9999_AAAA, 0, 1'b0);
        $display("[TB] response backpressure");
        applyStimulus(1'b0, 16'h0060, 32'h0, 4'hF, 1, 0, 32'hBBBB_CCCC, 5, 1'b1);
        $display("[TB] reset during a wait state");
        resetMidBus();
        applyStimulus(1'b0, 16'h0061, 32'h0, 4'hF, 4, 0, 32'hDDDD_EEEE, 0, 1'b0);

        $display("[TB] random transactions");
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
                          4'($urandom), int'($urandom_range(0, 10)),
                          int'($urandom_range(0, 3)), $urandom,
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
